// File: rtl/imem_responder_if.sv
// ============================================================================
//  Module      : imem_responder_if
//  Description : Fetch-side req/gnt/rvalid bus between fetch stage and imem.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_responder_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        flush;

  modport master (
    output req, addr, flush,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, flush,
    output gnt, rvalid, rdata, err
  );
endinterface

`default_nettype wire

// File: rtl/imem_responder.sv
// ============================================================================
//  Module      : imem_responder
//  Description : Instruction memory with fixed-latency in-order fetch responses,
//                outstanding-fetch limit, flush and backdoor preload port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_responder #(
  parameter int          DEPTH_WORDS     = 1024,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] BASE_ADDR       = 32'h0
) (
  input  wire logic        clk_i,
  input  wire logic        rst_ni,
  imem_responder_if.slave  bus,
  input  wire logic        we_i,
  input  wire logic [31:0] waddr_i,
  input  wire logic [31:0] wdata_i
);

  localparam int              AW      = $clog2(DEPTH_WORDS);
  localparam int              CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [29:0]     DEPTH_W = 30'(DEPTH_WORDS);
  localparam logic [CW-1:0]   MAX_C   = CW'(MAX_OUTSTANDING);

  logic [31:0]              mem_q [DEPTH_WORDS];

  logic [LATENCY-1:0]       valid_q, valid_d;
  logic [LATENCY-1:0][31:0] data_q,  data_d;
  logic [LATENCY-1:0]       err_q,   err_d;
  logic [CW-1:0]            cnt_q,   cnt_d;

  logic                     gnt;
  logic                     retire;
  logic [29:0]              rd_woff;
  logic                     rd_err;
  logic [31:0]              rd_data;
  logic [29:0]              wr_woff;
  logic                     wr_en;

  // Word offsets are taken from the word-address bits so both ports share one range test.
  assign rd_woff = bus.addr[31:2] - BASE_ADDR[31:2];
  assign rd_err  = (bus.addr[1:0] != 2'b00) || (bus.addr < BASE_ADDR) || (rd_woff >= DEPTH_W);
  assign rd_data = rd_err ? 32'h0 : mem_q[rd_woff[AW-1:0]];

  assign wr_woff = waddr_i[31:2] - BASE_ADDR[31:2];
  assign wr_en   = we_i && (waddr_i[1:0] == 2'b00) && (waddr_i >= BASE_ADDR) && (wr_woff < DEPTH_W);

  assign gnt    = rst_ni & bus.req & (cnt_q < MAX_C);
  assign retire = valid_q[LATENCY-1] & ~bus.flush;

  assign bus.gnt    = gnt;
  assign bus.rvalid = retire;
  assign bus.rdata  = retire ? data_q[LATENCY-1] : 32'h0;
  assign bus.err    = retire & err_q[LATENCY-1];

  // Reads see the pre-write contents, giving old data on a same-cycle collision.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_woff[AW-1:0]] <= wdata_i;
    end
  end

  always_comb begin
    valid_d    = '0;
    data_d     = data_q;
    err_d      = err_q;
    valid_d[0] = gnt;
    data_d[0]  = gnt ? rd_data : 32'h0;
    err_d[0]   = gnt & rd_err;
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1] & ~bus.flush;
      data_d[i]  = data_q[i-1];
      err_d[i]   = err_q[i-1];
    end
  end

  // A flush forgets everything in flight; only this cycle's grant survives.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.flush) begin
      cnt_d = CW'(gnt);
    end else if (gnt && !retire) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!gnt && retire && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      data_q  <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire
